pll_supervisor: RTL and testbench
=================================

# pll_supervisor

Multi-channel PLL supervisor running on the board reference clock (27 MHz). For each of NUM_PLL Gowin rPLL instances it sequences the PLL reset, waits for lock with timeout and bounded retry, and qualifies lock stability. It then releases a per-channel reset request to the clock domain fed by that PLL, and re-acquires lock after any loss. It sits between the board oscillator, the rPLL wrappers and the SoC reset synchronizers.

## Interface
- NUM_PLL, 1 — number of supervised PLLs (1..4)
- SYNC_STAGES, 2 — lock synchronizer depth (≥2)
- PLL_RST_CYCLES, 16 — PLL reset pulse width, clkin cycles (≥1)
- LOCK_STABLE_CYCLES, 1024 — consecutive synchronized-lock cycles required (≥1)
- LOCK_TIMEOUT, 65536 — max WAIT_LOCK cycles per attempt (≥2)
- MAX_RETRY, 3 — failed attempts tolerated before FAULT (≥0)
- clkin  in  1  reference clock; never gated by this block
- reset  in  1  synchronous, active-high
- pll_lock  in  NUM_PLL  raw asynchronous lock from each rPLL
- pll_reset  out  NUM_PLL  reset to each rPLL's RESET pin, active-high
- rst_out  out  NUM_PLL  reset request to each PLL clock domain, active-high
- fault  out  NUM_PLL  channel exhausted retries; sticky until reset
- all_locked  out  1  every channel in RUN
- relock_cnt  out  8*NUM_PLL  per-channel count of lock losses in RUN, saturating at 255

## Operation
- Each channel runs an independent FSM: PRST, WAIT, STABLE, RUN, FAULT. There is one shared cycle counter per channel. Width is $clog2 of the largest count parameter plus 1.
- Transitions:
  - PRST: pll_reset=1 for PLL_RST_CYCLES cycles, then go to WAIT with the counter cleared.
  - WAIT: lock_s=1 goes to STABLE with the counter cleared. If the counter reaches LOCK_TIMEOUT-1 with lock_s=0:
    - retry < MAX_RETRY: retry++, go to PRST.
    - otherwise: go to FAULT.
  - STABLE: lock_s=0 goes to WAIT with the counter cleared; retry is not incremented. Counter reaching LOCK_STABLE_CYCLES-1 with lock_s=1 goes to RUN.
  - RUN: lock_s=0 goes to PRST and increments relock_cnt (saturating). retry is cleared on RUN entry.
  - FAULT: terminal; pll_reset=1, fault=1. Only reset exits.
- lock_s is pll_lock passed through SYNC_STAGES flops.
- Outputs are registered and decoded from the next state:
  - pll_reset=1 in PRST and FAULT.
  - rst_out=0 only in RUN.
  - all_locked = AND of per-channel RUN.
- Channels never interact except through all_locked.
- Reset values: state PRST, counter 0, retry 0, sync flops 0, pll_reset all 1, rst_out all 1, fault 0, all_locked 0, relock_cnt 0.
- Reset mid-operation (any state, including FAULT) returns the channel to PRST on the next edge. The PRST pulse restarts at full width.
- With MAX_RETRY=0, the first timeout goes straight to FAULT.

## Timing
- Reset released at edge 0: pll_reset is high for exactly PLL_RST_CYCLES cycles after reset deassertion.
- pll_lock rising while in WAIT: lock_s follows SYNC_STAGES edges later. STABLE lasts LOCK_STABLE_CYCLES cycles. rst_out falls on the first RUN cycle, so total latency is SYNC_STAGES+LOCK_STABLE_CYCLES+1 edges from the sampled rise.
- pll_lock falling in RUN: rst_out rises and pll_reset rises on the same edge, SYNC_STAGES+1 edges after the sampled fall.
- Lock glitches shorter than one clkin period may be missed. This is acceptable; the PLL holds lock low for many cycles on loss.

## Configuration
- PLL_SUPERVISOR_STATS_EN defined: relock_cnt counters are implemented as specified.
- Not defined: relock_cnt is tied to 0 and no counter flops are present. The FSM is unchanged.

## Structure
- Package pll_supervisor_pkg holds:
  - the state enum (PRST, WAIT, STABLE, RUN, FAULT)
  - the 8-bit relock counter width constant
  - a function computing the counter width from the parameters
- Sub-module pll_supervisor_ch implements one channel: synchronizer, FSM, counter, retry, relock_cnt. The top is a generate loop plus the all_locked reduction.

## Test plan
All scenarios use NUM_PLL=2, SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT=32, MAX_RETRY=2.

- Clean bring-up: pll_lock[0] held high from cycle 0.
  - Expect pll_reset[0] high for cycles 1..4.
  - Expect rst_out[0] falling exactly 11 edges after the first WAIT cycle.
  - Expect all_locked=0 until channel 1 also locks.
- Stability glitch: during STABLE, drop lock for 3 cycles.
  - Expect a return to WAIT with no PRST and the retry count unchanged.
  - After lock returns, expect RUN 8 cycles after lock_s re-rises.
- Loss in RUN: drop pll_lock[1] for 20 cycles.
  - Expect rst_out[1] and pll_reset[1] rising 3 edges after the fall.
  - Expect relock_cnt[1]=1, then a normal re-lock; channel 0 is unaffected.
- Timeout and fault: pll_lock[0] held low.
  - Expect 3 PRST pulses of 4 cycles, each separated by 32 WAIT cycles.
  - Then expect FAULT: fault[0]=1, pll_reset[0]=1, rst_out[0]=1.
  - Asserting reset clears fault[0] and restarts PRST.
- Saturation: 300 lock losses in RUN -> relock_cnt=255. With PLL_SUPERVISOR_STATS_EN undefined -> relock_cnt stays 0.
- Reset mid-STABLE: assert reset for 1 cycle -> all outputs return to their reset values and a full 4-cycle PRST follows.

Source files
------------

// File: rtl/pll_supervisor_pkg.sv
// pll_supervisor_pkg: shared types and helpers for the PLL supervisor.
// Contents: channel state enum, relock counter width, cycle counter width function.
// Optional feature macro used by the design: PLL_SUPERVISOR_STATS_EN.
package pll_supervisor_pkg;
    typedef enum logic [2:0] {PRST, WAIT, STABLE, RUN, FAULT} state_t;
    localparam int RELOCK_W = 8;
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m) + 1;
    endfunction
endpackage

// File: rtl/pll_supervisor_ch.sv
// pll_supervisor_ch: one PLL channel (lock synchronizer, sequencing FSM, retry, relock stats).
// Ports: clkin/reset (sync, active-high), pll_lock (raw async lock in),
//        pll_reset (to rPLL RESET), rst_out (domain reset request), fault (sticky),
//        run (channel in RUN), relock_cnt (losses in RUN, saturating).
// PLL_SUPERVISOR_STATS_EN: when defined relock_cnt is a live counter, else tied to 0.
module pll_supervisor_ch
    import pll_supervisor_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int MAX_RETRY          = 3
) (
    input  logic                clkin,
    input  logic                reset,
    input  logic                pll_lock,
    output logic                pll_reset,
    output logic                rst_out,
    output logic                fault,
    output logic                run,
    output logic [RELOCK_W-1:0] relock_cnt
);
    localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT);
    localparam int RW = $clog2(MAX_RETRY + 2);

    state_t                 state, nxt;
    logic [CW-1:0]          cnt, cnt_n;
    logic [RW-1:0]          retry, retry_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                   lock_s;

    assign lock_s = sync[SYNC_STAGES-1];

    always_comb begin
        nxt     = state;
        cnt_n   = cnt + 1'b1;
        retry_n = retry;
        case (state)
            PRST:
                if (cnt == CW'(PLL_RST_CYCLES - 1)) begin
                    nxt   = WAIT;
                    cnt_n = '0;
                end
            WAIT:
                if (lock_s) begin
                    nxt   = STABLE;
                    cnt_n = '0;
                end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    cnt_n = '0;
                    if (int'(retry) < MAX_RETRY) begin
                        nxt     = PRST;
                        retry_n = retry + 1'b1;
                    end else begin
                        nxt = FAULT;
                    end
                end
            STABLE:
                if (!lock_s) begin
                    nxt   = WAIT;
                    cnt_n = '0;
                end else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
                    nxt     = RUN;
                    cnt_n   = '0;
                    retry_n = '0;
                end
            RUN: begin
                cnt_n = '0;
                if (!lock_s) nxt = PRST;
            end
            default: cnt_n = '0;
        endcase
    end

    // The synchronizer is flushed while the PLL is held in reset so a stale
    // lock level never counts toward the next attempt.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state     <= PRST;
            cnt       <= '0;
            retry     <= '0;
            sync      <= '0;
            pll_reset <= 1'b1;
            rst_out   <= 1'b1;
            fault     <= 1'b0;
            run       <= 1'b0;
        end else begin
            state     <= nxt;
            cnt       <= cnt_n;
            retry     <= retry_n;
            sync      <= (state == PRST || state == FAULT) ? '0 : {sync[SYNC_STAGES-2:0], pll_lock};
            pll_reset <= nxt == PRST || nxt == FAULT;
            rst_out   <= nxt != RUN;
            fault     <= nxt == FAULT;
            run       <= nxt == RUN;
        end
    end

`ifdef PLL_SUPERVISOR_STATS_EN
    always_ff @(posedge clkin) begin
        if (reset) relock_cnt <= '0;
        else if (state == RUN && !lock_s && relock_cnt != '1) relock_cnt <= relock_cnt + 1'b1;
    end
`else
    assign relock_cnt = '0;
`endif
endmodule

// File: rtl/pll_supervisor.sv
// pll_supervisor: multi-channel rPLL reset sequencer and lock qualifier.
// Ports: clkin/reset (sync, active-high), pll_lock[NUM_PLL] (raw lock),
//        pll_reset, rst_out, fault (per channel), all_locked (all in RUN),
//        relock_cnt (8 bits per channel).
// PLL_SUPERVISOR_STATS_EN: enables the per-channel relock counters.
module pll_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int NUM_PLL            = 1,
    parameter int SYNC_STAGES        = 2,
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int MAX_RETRY          = 3
) (
    input  logic                        clkin,
    input  logic                        reset,
    input  logic [NUM_PLL-1:0]          pll_lock,
    output logic [NUM_PLL-1:0]          pll_reset,
    output logic [NUM_PLL-1:0]          rst_out,
    output logic [NUM_PLL-1:0]          fault,
    output logic                        all_locked,
    output logic [RELOCK_W*NUM_PLL-1:0] relock_cnt
);
    logic [NUM_PLL-1:0] run;

    for (genvar i = 0; i < NUM_PLL; i++) begin : g_ch
        pll_supervisor_ch #(
            .SYNC_STAGES       (SYNC_STAGES),
            .PLL_RST_CYCLES    (PLL_RST_CYCLES),
            .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES),
            .LOCK_TIMEOUT      (LOCK_TIMEOUT),
            .MAX_RETRY         (MAX_RETRY)
        ) u_ch (
            .clkin     (clkin),
            .reset     (reset),
            .pll_lock  (pll_lock[i]),
            .pll_reset (pll_reset[i]),
            .rst_out   (rst_out[i]),
            .fault     (fault[i]),
            .run       (run[i]),
            .relock_cnt(relock_cnt[i*RELOCK_W +: RELOCK_W])
        );
    end

    assign all_locked = &run;
endmodule

// File: tb/tb_pll_supervisor.sv
// tb_pll_supervisor: directed self-checking bench for pll_supervisor (2 channels).
module tb_pll_supervisor;
`ifdef PLL_SUPERVISOR_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clkin = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  pll_lock = 2'b00;
    logic [1:0]  pll_reset, rst_out, fault;
    logic        all_locked;
    logic [15:0] relock_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    logic arm = 1'b0;
    logic pr1_seen = 1'b0;

    pll_supervisor #(
        .NUM_PLL(2), .SYNC_STAGES(2), .PLL_RST_CYCLES(4),
        .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT(32), .MAX_RETRY(2)
    ) dut (
        .clkin(clkin), .reset(reset), .pll_lock(pll_lock), .pll_reset(pll_reset),
        .rst_out(rst_out), .fault(fault), .all_locked(all_locked), .relock_cnt(relock_cnt)
    );

    always #5 clkin = ~clkin;

    always @(negedge clkin) if (arm && pll_reset[1]) pr1_seen <= 1'b1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clkin);
        @(negedge clkin);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel, input int ch);
        case (sel)
            0:       return rst_out[ch];
            1:       return pll_reset[ch];
            2:       return fault[ch];
            default: return all_locked;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int sel, input int ch, input logic v,
                            input int lim, output int n);
        n = 0;
        while (sig(sel, ch) !== v && n < lim) begin
            tick;
            n++;
        end
        chk({tag, "_seen"}, 32'(sig(sel, ch)), 32'(v));
    endtask

    task automatic wait_exp(input string tag, input int sel, input int ch, input logic v);
        int e, n;
        e = exp_q.pop_front();
        wait_for(tag, sel, ch, v, e + 8, n);
        chk(tag, n, e);
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_pll_reset"}, pll_reset, 3);
        chk({p, "_rst_out"}, rst_out, 3);
        chk({p, "_fault"}, fault, 0);
        chk({p, "_all_locked"}, all_locked, 0);
        chk({p, "_relock_cnt"}, relock_cnt, 0);
    endtask

    initial begin
        int n;
        repeat (3) tick;
        check_reset_vals("por");

        pll_lock = 2'b01;
        exp_q.push_back(4);
        reset = 1'b0;
        wait_exp("prst0_width", 1, 0, 1'b0);
        exp_q.push_back(11);
        wait_exp("up0_latency", 0, 0, 1'b0);
        chk("all_locked_one_ch", all_locked, 0);
        chk("rst1_still_high", rst_out[1], 1);

        exp_q.push_back(11);
        pll_lock[1] = 1'b1;
        wait_exp("up1_latency", 0, 1, 1'b0);
        chk("all_locked_both", all_locked, 1);

        exp_q.push_back(3);
        pll_lock[1] = 1'b0;
        wait_exp("loss1_pll_reset", 1, 1, 1'b1);
        chk("loss1_rst_out", rst_out[1], 1);
        chk("loss1_relock", relock_cnt[15:8], STATS);
        chk("loss1_ch0_run", rst_out[0], 0);
        chk("loss1_all_locked", all_locked, 0);

        repeat (17) tick;
        pll_lock[1] = 1'b1;
        repeat (5) tick;
        chk("glitch_in_stable", rst_out[1], 1);
        arm = 1'b1;
        pll_lock[1] = 1'b0;
        repeat (3) tick;
        exp_q.push_back(11);
        pll_lock[1] = 1'b1;
        wait_exp("glitch_relock", 0, 1, 1'b0);
        arm = 1'b0;
        chk("glitch_no_prst", pr1_seen, 0);
        chk("glitch_relock_cnt", relock_cnt[15:8], STATS);

        exp_q.push_back(3);
        pll_lock[0] = 1'b0;
        wait_exp("loss0_pll_reset", 1, 0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(4);
            wait_exp("to_prst_width", 1, 0, 1'b0);
            chk("to_no_fault", fault[0], 0);
            exp_q.push_back(32);
            wait_exp("to_wait_width", 1, 0, 1'b1);
        end
        chk("fault0_set", fault[0], 1);
        chk("fault0_rst_out", rst_out[0], 1);
        chk("fault0_relock", relock_cnt[7:0], STATS);
        repeat (40) tick;
        chk("fault0_sticky", fault[0], 1);
        chk("fault0_pll_reset", pll_reset[0], 1);
        chk("fault_ch1_clear", fault[1], 0);
        chk("fault_ch1_run", rst_out[1], 0);

        reset = 1'b1;
        tick;
        check_reset_vals("rst_fault");
        pll_lock[0] = 1'b1;
        exp_q.push_back(4);
        reset = 1'b0;
        wait_exp("prst_after_fault", 1, 0, 1'b0);
        repeat (5) tick;
        chk("mid_stable_not_run", rst_out[0], 1);
        reset = 1'b1;
        tick;
        check_reset_vals("rst_stable");
        exp_q.push_back(4);
        reset = 1'b0;
        wait_exp("prst_full_width", 1, 0, 1'b0);
        exp_q.push_back(11);
        wait_exp("up0_after_reset", 0, 0, 1'b0);
        chk("all_locked_after_reset", all_locked, 1);

        for (int k = 0; k < 300; k++) begin
            pll_lock[1] = 1'b0;
            wait_for("sat_loss", 1, 1, 1'b1, 10, n);
            pll_lock[1] = 1'b1;
            wait_for("sat_relock", 0, 1, 1'b0, 30, n);
        end
        chk("sat_relock_cnt1", relock_cnt[15:8], STATS ? 255 : 0);
        chk("sat_relock_cnt0", relock_cnt[7:0], 0);
        chk("sat_ch0_run", rst_out[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
